spi_reg_peripheral: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_reg_peripheral.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register peripheral.
// Register map, frame geometry and controller FSM states.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage pin synchronizer with one-clock rise/fall pulses.
// Edges are masked until the chain has flushed after reset so preset values never fake an edge.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   warm;

  // synchronizer chain, edge-history flop and post-reset warm-up mask
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      warm  <= {(STAGES+1){1'b0}};
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      warm  <= {warm[STAGES-1:0], 1'b1};
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = warm[STAGES] &  level & ~prev;
  assign fall  = warm[STAGES] & ~level &  prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI Mode-0 responder holding the PWM control registers.
// 16-bit frames: R/W, 7-bit address, 8-bit data, MSB first; read data returned on CIPO.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              cipo,
  output logic              cipo_oe,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_strobe
);

  localparam int FW = 1 + ADDR_W + DATA_W;

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_s), .rise(copi_rise), .fall(copi_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  assign unused_sync = ^{sclk_level, copi_rise, copi_fall, ncs_level};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [FW-1:0]     shift, shift_nxt;
  logic [DATA_W-1:0] rd_shift, rd_nxt;
  logic              cipo_nxt, oe_nxt;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_val;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              commit_wr;

  // Header completes on the rise that brings the count to ADDR_W+1, so the last address bit is still on copi_s.
  assign rd_addr    = {shift[ADDR_W-2:0], copi_s};
  assign frame_addr = shift[FW-2:DATA_W];
  assign frame_data = shift[DATA_W-1:0];
  assign commit_wr  = (state == COMMIT) && (cnt == CNT_W'(FW)) && shift[FW-1]
                      && (frame_addr < ADDR_W'(NUM_REGS));

  // read-back mux; unimplemented addresses read as zero
  always_comb begin
    rd_val = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val = (rd_addr == ADDR_W'(i)) ? regs[i] : rd_val;
    end
  end

  // FSM next-state and datapath next values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    rd_nxt    = rd_shift;
    cipo_nxt  = cipo;
    oe_nxt    = cipo_oe;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          state_nxt = ACTIVE;
          cnt_nxt   = {CNT_W{1'b0}};
          shift_nxt = {FW{1'b0}};
          rd_nxt    = {DATA_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        if (ncs_rise) begin
          state_nxt = COMMIT;
        end else if (sclk_rise) begin
          shift_nxt = {shift[FW-2:0], copi_s};
          cnt_nxt   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 5'd1;
          if ((cnt == CNT_W'(ADDR_W)) && !shift[ADDR_W-1]) begin
            rd_nxt = rd_val;
            oe_nxt = 1'b1;
          end else begin
            rd_nxt = rd_shift;
            oe_nxt = cipo_oe;
          end
        end else if (sclk_fall && cipo_oe) begin
          cipo_nxt = rd_shift[DATA_W-1];
          rd_nxt   = {rd_shift[DATA_W-2:0], 1'b0};
        end else begin
          state_nxt = ACTIVE;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
        cipo_nxt  = 1'b0;
        oe_nxt    = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        cipo_nxt  = 1'b0;
        oe_nxt    = 1'b0;
      end
    endcase
  end

  // FSM state, frame shifter and CIPO output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= {CNT_W{1'b0}};
      shift     <= {FW{1'b0}};
      rd_shift  <= {DATA_W{1'b0}};
      cipo      <= 1'b0;
      cipo_oe   <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shift     <= shift_nxt;
      rd_shift  <= rd_nxt;
      cipo      <= cipo_nxt;
      cipo_oe   <= oe_nxt;
      wr_strobe <= commit_wr;
    end
  end

  // register file, written only by a complete 16-bit write frame
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else if (commit_wr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frame_addr == ADDR_W'(i)) begin
          regs[i] <= frame_data;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench for spi_reg_peripheral: directed SPI frames push expected writes/reads,
// monitors pop and compare on wr_strobe and on each completed CIPO byte.
module tb_spi_reg_peripheral;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic       cipo, cipo_oe, wr_strobe;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  spi_reg_peripheral #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } wr_exp_t;

  wr_exp_t    exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] model [5];

  int   checks = 0;
  int   errors = 0;
  int   ncs_rise_cyc = 0;
  int   cur_bit = 0;
  bit   rd_active = 1'b0;
  bit   oe_allowed = 1'b0;
  int   oe_viol = 0;
  int   oe_miss = 0;
  int   rd_cnt = 0;
  logic [7:0] rd_byte = 8'h00;

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_vec();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // write monitor: each wr_strobe pops one expected write; also tracks illegal cipo_oe
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
    end
    if (cipo_oe && !oe_allowed) oe_viol++;
    if (wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_wr_strobe", 64'(1), 64'(0));
      end else begin
        wr_exp_t e;
        e = exp_wr_q.pop_front();
        model[e.idx] = e.val;
        check("wr_latency", 64'(cyc - ncs_rise_cyc), 64'(SYNC + 2));
        check("regs_after_write", 64'(dut_regs()), 64'(model_vec()));
      end
    end
  end

  // read monitor: samples CIPO on SCLK rise during the data phase of a read frame
  always @(posedge sclk) begin
    if (rd_active && cur_bit >= 8) begin
      if (!cipo_oe) oe_miss++;
      rd_byte = {rd_byte[6:0], cipo};
      rd_cnt++;
      if (rd_cnt == 8) begin
        rd_cnt = 0;
        if (exp_rd_q.size() == 0) check("unexpected_read", 64'(1), 64'(0));
        else check("read_data", 64'(rd_byte), 64'(exp_rd_q.pop_front()));
      end
    end
  end

  // SCLK = clk/10; COPI changes while SCLK is low
  task automatic spi_frame(input logic [31:0] word, input int nbits,
                           input bit do_fall, input bit do_rise, input bit is_rd);
    if (do_fall) ncs = 1'b0;
    rd_active = is_rd;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi    = word[nbits-1-i];
      cur_bit = i;
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      if (is_rd && i == 7) oe_allowed = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (do_rise) begin
      ncs = 1'b1;
      ncs_rise_cyc = cyc;
    end
    repeat (SYNC + 4) @(negedge clk);
    oe_allowed = 1'b0;
    rd_active  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_regs", 64'(dut_regs()), 64'(0));
    check("reset_cipo_oe", 64'(cipo_oe), 64'(0));
    check("reset_cipo", 64'(cipo), 64'(0));
    check("reset_wr_strobe", 64'(wr_strobe), 64'(0));
    repeat (20) @(negedge clk);

    exp_wr_q.push_back('{0, 8'hF0});
    spi_frame(32'h80F0, 16, 1'b1, 1'b1, 1'b0);
    check("reg0_written", 64'(en_reg_out_7_0), 64'(8'hF0));

    exp_wr_q.push_back('{4, 8'h80});
    spi_frame(32'h8480, 16, 1'b1, 1'b1, 1'b0);
    check("duty_written", 64'(pwm_duty_cycle), 64'(8'h80));

    exp_rd_q.push_back(8'h80);
    spi_frame(32'h0400, 16, 1'b1, 1'b1, 1'b1);
    exp_rd_q.push_back(8'hF0);
    spi_frame(32'h0000, 16, 1'b1, 1'b1, 1'b1);
    exp_rd_q.push_back(8'h00);
    spi_frame(32'h0500, 16, 1'b1, 1'b1, 1'b1);

    spi_frame(32'h85AA, 16, 1'b1, 1'b1, 1'b0);
    spi_frame(32'h081F, 12, 1'b1, 1'b1, 1'b0);
    check("regs_after_bad_addr_and_abort", 64'(dut_regs()), 64'(40'h80_00_00_00_F0));

    spi_frame(32'h104AB, 17, 1'b1, 1'b1, 1'b0);
    check("pwm_lo_after_17_bits", 64'(en_reg_pwm_7_0), 64'(8'h00));

    spi_frame(32'h020E, 10, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_frame_reset_regs", 64'(dut_regs()), 64'(0));
    check("mid_frame_reset_oe", 64'(cipo_oe), 64'(0));
    spi_frame(32'h8377, 16, 1'b0, 1'b1, 1'b0);
    check("no_frame_without_fresh_fall", 64'(dut_regs()), 64'(0));
    exp_wr_q.push_back('{3, 8'h01});
    spi_frame(32'h8301, 16, 1'b1, 1'b1, 1'b0);
    check("pwm_hi_written", 64'(en_reg_pwm_15_8), 64'(8'h01));

    repeat (20) @(negedge clk);
    check("pending_writes", 64'(exp_wr_q.size()), 64'(0));
    check("pending_reads", 64'(exp_rd_q.size()), 64'(0));
    check("cipo_oe_outside_data_phase", 64'(oe_viol), 64'(0));
    check("cipo_oe_missing_in_data_phase", 64'(oe_miss), 64'(0));
    check("final_regs", 64'(dut_regs()), 64'(model_vec()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, expected under 60000", cyc);
    $fatal(1, "timeout");
  end

endmodule
